// File: rtl/conv_engine.sv
`default_nettype none
// ============================================================================
//  Module   : conv_engine
//  Purpose  : Streaming KxK 2-D convolution engine with a memory-mapped
//             register block. Pixels arrive in raster order, K-1 line buffers
//             and a KxK window hold the neighbourhood, and one
//             multiply-accumulate runs per cycle. Each result is shifted,
//             saturated to the pixel range and returned through a
//             valid/ready output port.
//  Ports    : clk, rst              clock, asynchronous active-high reset
//             req/we/addr/wdata     register access request
//             ack/rdata             acknowledge (one cycle later) and read data
//             pix_valid/pix_data/pix_ready   input pixel stream
//             res_valid/res_data/res_ready   output result stream
//             done_irq              one-cycle frame-complete pulse
//  Revision : 1.0  initial release
// ============================================================================
module conv_engine #(
    parameter int          MWSIZE    = 7,
    parameter int          MAX_W     = 640,
    parameter int          PIX_W     = 8,
    parameter int          COEF_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h00100030
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              res_valid,
    output logic [PIX_W-1:0]  res_data,
    input  logic              res_ready,
    output logic              done_irq
);

    localparam int c_NCOEF  = MWSIZE * MWSIZE;
    localparam int c_CIW    = $clog2(c_NCOEF);
    localparam int c_NW     = $clog2(c_NCOEF + 1);
    localparam int c_KW     = $clog2(MWSIZE + 1);
    localparam int c_KI     = $clog2(MWSIZE);
    localparam int c_XW     = $clog2(MAX_W);
    localparam int c_CW     = $clog2(MAX_W + 1);
    localparam int c_HW     = 16;
    localparam int c_ACC_W  = PIX_W + COEF_W + 6;
    localparam int c_PROD_W = PIX_W + COEF_W + 1;

    localparam logic [31:0] c_OFF_CTRL   = 32'h00;
    localparam logic [31:0] c_OFF_STATUS = 32'h04;
    localparam logic [31:0] c_OFF_WSIZE  = 32'h08;
    localparam logic [31:0] c_OFF_IMG_W  = 32'h0C;
    localparam logic [31:0] c_OFF_IMG_H  = 32'h10;
    localparam logic [31:0] c_OFF_SHIFT  = 32'h14;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_MAC  = 3'd2;
    localparam logic [2:0] c_OUT  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic signed [c_ACC_W-1:0] c_PMAX = {{(c_ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

    // ------------------------------------------------------------------
    // State and configuration
    // ------------------------------------------------------------------
    logic [2:0]              r_state;
    logic [c_KW-1:0]         r_wsize;
    logic [c_CW-1:0]         r_img_w;
    logic [c_HW-1:0]         r_img_h;
    logic [4:0]              r_shift;
    logic                    r_done;
    logic                    r_sat;
    logic                    r_irq;
    logic                    r_final;
    logic [c_HW-1:0]         r_row;
    logic [c_CW-1:0]         r_col;
    logic [c_NW-1:0]         r_cnt;
    logic [c_KW-1:0]         r_mi;
    logic [c_KW-1:0]         r_mj;
    logic signed [c_ACC_W-1:0] r_acc;
    logic [PIX_W-1:0]        r_res;

    // Storage without reset: contents are rewritten before use every frame
    logic [COEF_W-1:0]       r_coef [c_NCOEF];
    logic [PIX_W-1:0]        r_lb   [MWSIZE-1][MAX_W];
    logic [PIX_W-1:0]        r_win  [MWSIZE][MWSIZE];

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic [31:0] w_off;
    logic [29:0] w_cword;
    logic        w_coef_hit;
    logic        w_wr;
    logic        w_busy;
    logic        w_cfg_wr;
    logic        w_start;
    logic        w_abort;

    assign w_off      = addr - BASE_ADDR;
    assign w_cword    = w_off[31:2] - 30'd64;
    assign w_coef_hit = (w_off[1:0] == 2'b00) && (w_cword < 30'(c_NCOEF));
    assign w_wr       = req && we;
    assign w_busy     = (r_state == c_LOAD) || (r_state == c_MAC) || (r_state == c_OUT);
    assign w_cfg_wr   = w_wr && !w_busy;
    // A start alone only launches from IDLE/DONE; start+abort restarts from anywhere
    assign w_start    = w_wr && (w_off == c_OFF_CTRL) && wdata[0] && (!w_busy || wdata[1]);
    assign w_abort    = w_wr && (w_off == c_OFF_CTRL) && wdata[1] && !w_start;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic                      w_pix_hs;
    logic                      w_last_col;
    logic                      w_last_row;
    logic                      w_win_ok;
    logic [c_KW-1:0]           w_km1;
    logic [c_NW-1:0]           w_kk;
    logic [c_XW-1:0]           w_cidx;
    logic [c_KW-1:0]           w_wi;
    logic [c_KW-1:0]           w_wj;
    logic [PIX_W-1:0]          w_win_pix;
    logic [COEF_W-1:0]         w_coef;
    logic signed [c_PROD_W-1:0] w_pix_s;
    logic signed [c_PROD_W-1:0] w_coef_s;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_ACC_W-1:0]  w_prod_ext;
    logic signed [c_ACC_W-1:0]  w_shifted;
    logic [PIX_W-1:0]          w_sat_val;
    logic                      w_clip;

    assign w_pix_hs   = pix_valid && (r_state == c_LOAD);
    assign w_km1      = r_wsize - c_KW'(1);
    assign w_kk       = c_NW'(r_wsize) * c_NW'(r_wsize);
    assign w_last_col = (r_col == r_img_w - c_CW'(1));
    assign w_last_row = (r_row == r_img_h - c_HW'(1));
    assign w_win_ok   = (r_row >= c_HW'(w_km1)) && (r_col >= c_CW'(w_km1));
    assign w_cidx     = r_col[c_XW-1:0];

    // Window row/col 0 is the newest pixel, so tap (i,j) of the kernel
    // lives at window position (K-1-i, K-1-j).
    assign w_wi       = w_km1 - r_mi;
    assign w_wj       = w_km1 - r_mj;
    assign w_win_pix  = r_win[w_wi[c_KI-1:0]][w_wj[c_KI-1:0]];
    assign w_coef     = r_coef[r_cnt[c_CIW-1:0]];

    assign w_pix_s    = {{(COEF_W+1){1'b0}}, w_win_pix};
    assign w_coef_s   = {{(PIX_W+1){w_coef[COEF_W-1]}}, w_coef};
    assign w_prod     = w_pix_s * w_coef_s;
    assign w_prod_ext = {{(c_ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    assign w_shifted  = r_acc >>> r_shift;

    always_comb begin
        w_clip    = 1'b0;
        w_sat_val = w_shifted[PIX_W-1:0];
        if (w_shifted[c_ACC_W-1]) begin
            w_clip    = 1'b1;
            w_sat_val = '0;
        end else if (w_shifted > c_PMAX) begin
            w_clip    = 1'b1;
            w_sat_val = '1;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient memory, line buffers and window
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_cfg_wr && w_coef_hit) begin
            r_coef[w_cword[c_CIW-1:0]] <= wdata[COEF_W-1:0];
        end
        if (w_pix_hs) begin
            // Line buffer k holds row r-1-k at each column
            r_lb[0][w_cidx] <= pix_data;
            for (int k = 1; k < MWSIZE-1; k++) begin
                r_lb[k][w_cidx] <= r_lb[k-1][w_cidx];
            end
            for (int a = 0; a < MWSIZE; a++) begin
                for (int b = MWSIZE-1; b > 0; b--) begin
                    r_win[a][b] <= r_win[a][b-1];
                end
            end
            r_win[0][0] <= pix_data;
            for (int a = 1; a < MWSIZE; a++) begin
                r_win[a][0] <= r_lb[a-1][w_cidx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wsize <= c_KW'(3);
            r_img_w <= c_CW'(MAX_W);
            r_img_h <= '0;
            r_shift <= '0;
        end else if (w_cfg_wr) begin
            case (w_off)
                c_OFF_WSIZE: begin
                    if (wdata[0] && (wdata >= 32'd3) && (wdata <= 32'(MWSIZE))) begin
                        r_wsize <= wdata[c_KW-1:0];
                    end
                end
                c_OFF_IMG_W: begin
                    if (wdata > 32'(MAX_W)) begin
                        r_img_w <= c_CW'(MAX_W);
                    end else begin
                        r_img_w <= wdata[c_CW-1:0];
                    end
                end
                c_OFF_IMG_H: r_img_h <= wdata[c_HW-1:0];
                c_OFF_SHIFT: r_shift <= wdata[4:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
            r_irq   <= 1'b0;
            r_final <= 1'b0;
            r_cnt   <= '0;
            r_mi    <= '0;
            r_mj    <= '0;
            r_acc   <= '0;
            r_res   <= '0;
        end else begin
            r_irq <= 1'b0;
            if (w_start) begin
                r_state <= c_LOAD;
                r_row   <= '0;
                r_col   <= '0;
                r_done  <= 1'b0;
                r_sat   <= 1'b0;
            end else if (w_abort) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_LOAD: begin
                        if (pix_valid) begin
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + c_HW'(1);
                            end else begin
                                r_col <= r_col + c_CW'(1);
                            end
                            r_final <= w_last_col && w_last_row;
                            if (w_win_ok) begin
                                r_state <= c_MAC;
                                r_acc   <= '0;
                                r_cnt   <= '0;
                                r_mi    <= '0;
                                r_mj    <= '0;
                            end else if (w_last_col && w_last_row) begin
                                // Frame ended without any full window
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                                r_irq   <= 1'b1;
                            end
                        end
                    end
                    c_MAC: begin
                        // K*K accumulate cycles, then one cycle to saturate
                        if (r_cnt == w_kk) begin
                            r_res   <= w_sat_val;
                            r_state <= c_OUT;
                            if (w_clip) begin
                                r_sat <= 1'b1;
                            end
                        end else begin
                            r_acc <= r_acc + w_prod_ext;
                            r_cnt <= r_cnt + c_NW'(1);
                            if (r_mj == w_km1) begin
                                r_mj <= '0;
                                r_mi <= r_mi + c_KW'(1);
                            end else begin
                                r_mj <= r_mj + c_KW'(1);
                            end
                        end
                    end
                    c_OUT: begin
                        if (res_ready) begin
                            if (r_final) begin
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                                r_irq   <= 1'b1;
                            end else begin
                                r_state <= c_LOAD;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Register read port
    // ------------------------------------------------------------------
    logic [31:0] w_rd_val;

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            c_OFF_STATUS: w_rd_val = {29'd0, r_sat, r_done, w_busy};
            c_OFF_WSIZE:  w_rd_val = 32'(r_wsize);
            c_OFF_IMG_W:  w_rd_val = 32'(r_img_w);
            c_OFF_IMG_H:  w_rd_val = 32'(r_img_h);
            c_OFF_SHIFT:  w_rd_val = 32'(r_shift);
            default: begin
                if (w_coef_hit) begin
                    w_rd_val = 32'(r_coef[w_cword[c_CIW-1:0]]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= req;
            rdata <= (req && !we) ? w_rd_val : '0;
        end
    end

    assign pix_ready = (r_state == c_LOAD);
    assign res_valid = (r_state == c_OUT);
    assign res_data  = r_res;
    assign done_irq  = r_irq;

endmodule
`default_nettype wire

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter MWSIZE, default 7: maximum odd window size K.
REQ-002 SHALL have parameter MAX_W, default 640: maximum image width in pixels (line-buffer depth).
REQ-003 SHALL have parameter PIX_W, default 8, and COEF_W, default 8: unsigned pixel width and signed coefficient width.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h00100030: register block base address.
REQ-005 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- req  in  1  register access request
- we  in  1  write enable
- addr  in  32  byte address
- wdata  in  32  write data
- ack  out  1  access acknowledge
- rdata  out  32  read data
- pix_valid  in  1  input pixel valid
- pix_data  in  PIX_W  input pixel
- pix_ready  out  1  input pixel accepted
- res_valid  out  1  result valid
- res_data  out  PIX_W  result pixel
- res_ready  in  1  result consumed
- done_irq  out  1  frame-complete pulse

Function
REQ-006 SHALL assert ack exactly one cycle after every req; rdata valid in that ack cycle; unmapped reads return 0.
REQ-007 SHALL decode these offsets from BASE_ADDR:
- 0x00 CTRL: bit0 start, bit1 abort; write-only, self-clearing.
- 0x04 STATUS: bit0 busy, bit1 done, bit2 sat_seen; read-only.
- 0x08 WSIZE; 0x0C IMG_W; 0x10 IMG_H; 0x14 SHIFT, 5 bits.
- 0x100+4*k: COEF[k], k < MWSIZE*MWSIZE; bits [COEF_W-1:0] used.
REQ-008 SHALL ignore writes to WSIZE/IMG_W/IMG_H/SHIFT/COEF while busy; reads remain allowed.
REQ-009 SHALL accept a WSIZE write only for odd values 3..MWSIZE, otherwise keep the previous value.
REQ-010 SHALL implement states IDLE, LOAD, MAC, OUT, DONE.
REQ-011 SHALL go IDLE/DONE->LOAD on a start write; clear row/col counters, done and sat_seen; set busy.
REQ-012 SHALL, in LOAD, assert pix_ready; on each handshake, write the pixel into K-1 line buffers and the KxK window, and advance col, wrapping at IMG_W-1 to row+1.
REQ-013 SHALL enter MAC after an accepted pixel at (r,c) with r>=K-1 and c>=K-1; otherwise stay in LOAD.
REQ-014 SHALL, in MAC, deassert pix_ready and perform one multiply-accumulate per cycle for K*K cycles.
- acc += COEF[i*K+j] * pixel(r-K+1+i, c-K+1+j).
- acc is signed, PIX_W+COEF_W+6 bits.
REQ-015 SHALL form the result as (acc >>> SHIFT) saturated to [0, 2^PIX_W-1], and set sat_seen if clipped.
REQ-016 SHALL, in OUT, hold res_valid and res_data stable until res_ready; on handshake go to LOAD, or to DONE if (r,c)=(IMG_H-1,IMG_W-1).
REQ-017 SHALL, on the last pixel with no output produced (IMG_H<K or IMG_W<K), go directly to DONE.
REQ-018 SHALL, on entering DONE, clear busy, set done, and pulse done_irq for exactly one cycle.
REQ-019 SHALL, on an abort write in any state, return to IDLE next cycle: res_valid and pix_ready low, busy low, done unchanged.
REQ-020 SHALL give start priority over abort when both bits are written together: abort, then restart.
REQ-021 SHALL have latency from the accepted window-completing pixel to res_valid of K*K+1 cycles.
REQ-022 SHALL produce (IMG_H-K+1)*(IMG_W-K+1) results per frame, in raster order.
REQ-023 SHALL clamp IMG_W writes above MAX_W to MAX_W.

Reset
REQ-024 SHALL, on rst, asynchronously return to IDLE.
- Zero: ack, rdata, pix_ready, res_valid, res_data, done_irq, and all STATUS bits.
- WSIZE=3, IMG_W=MAX_W, IMG_H=0, SHIFT=0.
- COEF contents undefined.
REQ-025 SHALL, on rst asserted mid-frame, discard the frame, with no result or done_irq after release.

Verification
REQ-026 SHALL cover identity 3x3: COEF[4]=1, others 0, IMG 4x4 ramp 0..15 -> results 5,6,9,10, then done_irq.
REQ-027 SHALL cover saturation: 3x3 all COEF=1, SHIFT=0, all pixels 200 -> result 255, sat_seen=1; with SHIFT=4 -> 112, sat_seen=0.
REQ-028 SHALL cover backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_data stable, pix_ready=0.
REQ-029 SHALL cover config protection: write WSIZE=4 -> reads 3; write WSIZE=5 while busy -> reads 3.
REQ-030 SHALL cover abort: abort during MAC -> IDLE next cycle, busy=0, no done_irq; a restart produces the full result set.
REQ-031 SHALL cover small image: IMG_H=2, K=3 -> zero results, done after 2*IMG_W pixels.
